// File: rtl/tone_period_meter.sv
// Measures the period of a 1-bit square-wave line in clock cycles, averaged over
// 2^AVG_LOG2 rising edges, with silence (timeout) and glitch (short period) flags.
module tone_period_meter #(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 2000000,
  parameter int MIN_PER  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sound_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             silent,
  output logic             glitch
);

  localparam int ACC_W = CNT_W + AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_s1, r_s2, r_s3;
  logic                 w_rise;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]     r_acc, w_acc_nxt;
  logic [ACC_W-1:0]     w_sum;
  logic [AVG_LOG2-1:0]  r_n, w_n_nxt;
  logic [CNT_W-1:0]     r_per, w_per_nxt;
  logic                 r_silent, w_silent_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_glitch, w_glitch_nxt;
  logic                 w_timeout;
  logic                 w_short;

  // Two-flop synchronizer plus a third flop for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sound_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
  assign w_short   = (r_cnt < CNT_W'(MIN_PER));
  assign w_sum     = r_acc + ACC_W'(r_cnt);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_n_nxt      = r_n;
    w_per_nxt    = r_per;
    w_silent_nxt = r_silent;
    w_valid_nxt  = 1'b0;
    w_glitch_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
      w_n_nxt     = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_n_nxt     = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_state_nxt  = MEAS;
            w_cnt_nxt    = CNT_W'(1);
            w_acc_nxt    = '0;
            w_n_nxt      = '0;
            w_silent_nxt = 1'b0;
          end else if (w_timeout) begin
            w_silent_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        MEAS: begin
          // A rise always closes a period, even on the timeout cycle.
          if (w_rise) begin
            w_cnt_nxt = CNT_W'(1);
            if (w_short) begin
              w_glitch_nxt = 1'b1;
              w_acc_nxt    = '0;
              w_n_nxt      = '0;
            end else if (r_n == '1) begin
              w_per_nxt   = w_sum[ACC_W-1:AVG_LOG2];
              w_valid_nxt = 1'b1;
              w_acc_nxt   = '0;
              w_n_nxt     = '0;
            end else begin
              w_acc_nxt = w_sum;
              w_n_nxt   = r_n + 1'b1;
            end
          end else if (w_timeout) begin
            w_state_nxt  = ARM;
            w_silent_nxt = 1'b1;
            w_cnt_nxt    = '0;
            w_acc_nxt    = '0;
            w_n_nxt      = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_n      <= '0;
      r_per    <= '0;
      r_silent <= 1'b1;
      r_valid  <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_n      <= w_n_nxt;
      r_per    <= w_per_nxt;
      r_silent <= w_silent_nxt;
      r_valid  <= w_valid_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  assign period_out   = r_per;
  assign period_valid = r_valid;
  assign silent       = r_silent;
  assign glitch       = r_glitch;

endmodule
